// File: rtl/spi_flash_dspi_responder.sv
// Dual-IO fast read (0xBB) SPI flash responder with continuous read mode.
// Serves read data from a 16-bit word memory; clk is the SPI clock.
module spi_flash_dspi_responder #(
  parameter int MEM_LATENCY = 2,
  parameter int DATA_DELAY  = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_cs_n,
  input  logic [1:0]  spi_io_in,
  output logic [1:0]  spi_io_out,
  output logic [1:0]  spi_io_oe,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic        cont_mode,
  output logic        cmd_error
);

  localparam logic [2:0] LP_LAT = 3'(MEM_LATENCY + 1);
  localparam logic [3:0] LP_DLY = 4'(DATA_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_MODE,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  state_t      w_phase;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt;
  logic [3:0]  w_cnt_n;
  logic [6:0]  r_cmd;
  logic [7:0]  w_cmd;
  logic [20:0] r_addr;
  logic [3:0]  r_mode;
  logic [13:0] r_sh;
  logic [15:0] r_next;
  logic [15:0] w_src;
  logic [2:0]  r_pair;
  logic [2:0]  r_lat;
  logic [1:0]  r_out;
  logic [1:0]  r_oe;
  logic [21:0] r_mem_addr;
  logic        r_rd;
  logic        r_cont;
  logic        r_err;
  logic        w_last_cmd;
  logic        w_last_addr;
  logic        w_last_mode;
  logic        w_last_dummy;
  logic        w_cap;
  logic        w_pair0;

  // An idle responder's first edge belongs to CMD, or to ADDR when armed.
  assign w_phase = (r_state == S_IDLE) ?
                   (r_cont ? S_ADDR : S_CMD) : r_state;
  assign w_cnt   = (r_state == S_IDLE) ? 4'd0 : r_cnt;
  assign w_cmd   = {r_cmd, spi_io_in[0]};

  assign w_last_cmd   = (w_phase == S_CMD)   && (w_cnt == 4'd7);
  assign w_last_addr  = (w_phase == S_ADDR)  && (w_cnt == 4'd11);
  assign w_last_mode  = (w_phase == S_MODE)  && (w_cnt == 4'd3);
  assign w_last_dummy = (w_phase == S_DUMMY) &&
                        ((w_cnt + 4'd1) == LP_DLY);

  // A word landing on the same edge it is needed bypasses r_next.
  assign w_cap   = (r_lat == 3'd1);
  assign w_src   = w_cap ? mem_data : r_next;
  assign w_pair0 = (w_phase == S_DATA) && (r_pair == 3'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_cnt + 4'd1;
    if (spi_cs_n) begin
      w_state_n = S_IDLE;
      w_cnt_n   = 4'd0;
    end else begin
      unique case (w_phase)
        S_CMD: begin
          w_state_n = S_CMD;
          if (w_last_cmd) begin
            w_state_n = (w_cmd == 8'hBB) ? S_ADDR : S_IGNORE;
            w_cnt_n   = 4'd0;
          end
        end
        S_ADDR: begin
          w_state_n = S_ADDR;
          if (w_last_addr) begin
            w_state_n = S_MODE;
            w_cnt_n   = 4'd0;
          end
        end
        S_MODE: begin
          w_state_n = S_MODE;
          if (w_last_mode) begin
            w_state_n = (LP_DLY == 4'd0) ? S_DATA : S_DUMMY;
            w_cnt_n   = 4'd0;
          end
        end
        S_DUMMY: begin
          w_state_n = S_DUMMY;
          if (w_last_dummy) begin
            w_state_n = S_DATA;
            w_cnt_n   = 4'd0;
          end
        end
        S_DATA: begin
          w_state_n = S_DATA;
          w_cnt_n   = 4'd0;
        end
        S_IGNORE: begin
          w_state_n = S_IGNORE;
          w_cnt_n   = 4'd0;
        end
        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd      <= 7'd0;
      r_addr     <= 21'd0;
      r_mode     <= 4'd0;
      r_sh       <= 14'd0;
      r_next     <= 16'd0;
      r_pair     <= 3'd0;
      r_lat      <= 3'd0;
      r_out      <= 2'b00;
      r_oe       <= 2'b00;
      r_mem_addr <= 22'd0;
      r_rd       <= 1'b0;
      r_cont     <= 1'b0;
      r_err      <= 1'b0;
    end else if (spi_cs_n) begin
      // Abort: drop partial words and any read still in flight.
      r_oe   <= 2'b00;
      r_out  <= 2'b00;
      r_rd   <= 1'b0;
      r_lat  <= 3'd0;
      r_pair <= 3'd0;
      if (r_state inside {S_CMD, S_ADDR, S_MODE})
        r_cont <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      if (r_lat != 3'd0)
        r_lat <= r_lat - 3'd1;
      if (w_cap)
        r_next <= mem_data;

      if (w_phase == S_CMD) begin
        r_cmd <= w_cmd[6:0];
        if (w_last_cmd && (w_cmd != 8'hBB) && (w_cmd != 8'hFF))
          r_err <= 1'b1;
      end

      if (w_phase == S_ADDR) begin
        r_addr <= {r_addr[18:0], spi_io_in};
        if (w_last_addr) begin
          r_mem_addr <= {r_addr, spi_io_in[1]};
          r_rd       <= 1'b1;
          r_lat      <= LP_LAT;
        end
      end

      if (w_phase == S_MODE) begin
        r_mode <= {r_mode[1:0], spi_io_in};
        if (w_last_mode)
          r_cont <= (r_mode[3:2] == 2'b10);
      end

      if (w_phase == S_DATA) begin
        r_oe   <= 2'b11;
        r_pair <= r_pair + 3'd1;
        if (w_pair0) begin
          r_out      <= w_src[15:14];
          r_sh       <= w_src[13:0];
          r_mem_addr <= r_mem_addr + 22'd1;
          r_rd       <= 1'b1;
          r_lat      <= LP_LAT;
        end else begin
          r_out <= r_sh[13:12];
          r_sh  <= {r_sh[11:0], 2'b00};
        end
      end
    end
  end

  assign spi_io_oe  = r_oe & {2{~spi_cs_n}};
  assign spi_io_out = r_out & spi_io_oe;
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_rd;
  assign cont_mode  = r_cont;
  assign cmd_error  = r_err;

endmodule
